// File: rtl/jk_bank_driver.sv
// rtl/jk_bank_driver.sv - drives a bank of external JK flip-flops to a target word and checks the result
module jk_bank_driver #(
    parameter int WIDTH = 4,
    parameter int STYLE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] tgt_r;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] j_next;
    logic [WIDTH-1:0] k_next;
    logic [WIDTH-1:0] mismatch;

    // Excitation is formed from the live target and Q at the accept edge so
    // that j/k are already registered and stable for the whole DRIVE cycle.
    always_comb begin
        diff   = tgt_data ^ q_fb;
        j_next = '0;
        k_next = '0;
        if (STYLE == 0) begin
            j_next = diff & tgt_data;
            k_next = diff & ~tgt_data;
        end else begin
            j_next = diff;
            k_next = diff;
        end
    end

    assign mismatch  = q_fb ^ tgt_r;
    assign tgt_ready = (state == IDLE) && !reset;
    assign busy      = (state == DRIVE) || (state == CHECK);

    // Accept -> drive for exactly one cycle -> check the bank's new Q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tgt_r     <= '0;
            j         <= '0;
            k         <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_mask  <= '0;
            err_count <= 8'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    j <= '0;
                    k <= '0;
                    if (tgt_valid) begin
                        tgt_r <= tgt_data;
                        j     <= j_next;
                        k     <= k_next;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    // The bank samples j/k at this edge; release them right after.
                    j     <= '0;
                    k     <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    j        <= '0;
                    k        <= '0;
                    done     <= 1'b1;
                    err      <= |mismatch;
                    err_mask <= mismatch;
                    if ((|mismatch) && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                    state <= IDLE;
                end
                default: begin
                    j     <= '0;
                    k     <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb/tb_jk_bank_driver.sv - self-checking bench for jk_bank_driver with behavioural JK banks
module tb_jk_bank_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tgt_valid = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] tgt_data = '0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] stuck = '0;

    logic       valid0, valid1, ready0, ready1, busy0, busy1;
    logic       done0, done1, err0, err1;
    logic [3:0] j0, k0, j1, k1, mask0, mask1, q_fb0, q_fb1;
    logic [7:0] cnt0, cnt1;
    logic [3:0] bq0 = '0;
    logic [3:0] bq1 = '0;

    logic       ready_s, busy_s, done_s, err_s;
    logic [3:0] j_s, k_s, mask_s, q_s;
    logic [7:0] cnt_s;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign valid0 = tgt_valid & ~sel;
    assign valid1 = tgt_valid & sel;
    assign q_fb0  = bq0 & ~stuck;
    assign q_fb1  = bq1 & ~stuck;

    // Behavioural JK banks clocked with the DUTs; load presets Q between tests.
    always @(posedge clk) begin
        if (load) begin
            bq0 <= load_val;
            bq1 <= load_val;
        end else begin
            bq0 <= (j0 & ~bq0) | (~k0 & bq0);
            bq1 <= (j1 & ~bq1) | (~k1 & bq1);
        end
    end

    assign ready_s = sel ? ready1 : ready0;
    assign busy_s  = sel ? busy1  : busy0;
    assign done_s  = sel ? done1  : done0;
    assign err_s   = sel ? err1   : err0;
    assign j_s     = sel ? j1     : j0;
    assign k_s     = sel ? k1     : k0;
    assign mask_s  = sel ? mask1  : mask0;
    assign q_s     = sel ? q_fb1  : q_fb0;
    assign cnt_s   = sel ? cnt1   : cnt0;

    jk_bank_driver #(.WIDTH(4), .STYLE(0)) dut0 (
        .clk(clk), .reset(reset), .tgt_valid(valid0), .tgt_data(tgt_data),
        .tgt_ready(ready0), .j(j0), .k(k0), .q_fb(q_fb0), .busy(busy0),
        .done(done0), .err(err0), .err_mask(mask0), .err_count(cnt0)
    );

    jk_bank_driver #(.WIDTH(4), .STYLE(1)) dut1 (
        .clk(clk), .reset(reset), .tgt_valid(valid1), .tgt_data(tgt_data),
        .tgt_ready(ready1), .j(j1), .k(k1), .q_fb(q_fb1), .busy(busy1),
        .done(done1), .err(err1), .err_mask(mask1), .err_count(cnt1)
    );

    typedef struct {
        logic       sel;
        logic [3:0] q0;
        logic [3:0] tgt;
        logic [3:0] ej;
        logic [3:0] ek;
        logic [3:0] eq;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_bank(input logic [3:0] v);
        @(negedge clk);
        load = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Full single transaction: accept, DRIVE, CHECK, done cycle, one hold cycle.
    task automatic run_txn(input logic s, input logic [3:0] q0, input logic [3:0] tgt,
                           input logic [3:0] ej, input logic [3:0] ek, input logic [3:0] eq,
                           input logic eerr, input logic [3:0] emask, input logic [7:0] ecnt);
        sel = s;
        load_bank(q0);
        chk("ready_idle", ready_s, 1);
        tgt_valid = 1'b1;
        tgt_data = tgt;
        @(negedge clk);
        tgt_valid = 1'b0;
        chk("drive_busy", busy_s, 1);
        chk("drive_ready", ready_s, 0);
        chk("drive_j", j_s, ej);
        chk("drive_k", k_s, ek);
        chk("drive_done", done_s, 0);
        @(negedge clk);
        chk("check_j", j_s, 0);
        chk("check_k", k_s, 0);
        chk("check_busy", busy_s, 1);
        chk("check_done", done_s, 0);
        @(negedge clk);
        chk("done", done_s, 1);
        chk("err", err_s, eerr);
        chk("err_mask", mask_s, emask);
        chk("err_count", cnt_s, ecnt);
        chk("done_busy", busy_s, 0);
        chk("done_ready", ready_s, 1);
        chk("bank_q", q_s, eq);
        @(negedge clk);
        chk("done_pulse", done_s, 0);
        chk("err_pulse", err_s, 0);
        chk("mask_hold", mask_s, emask);
    endtask

    logic [3:0] b2b_tgt[4];
    logic [3:0] b2b_j[4];
    logic [3:0] b2b_k[4];

    initial begin
        vecs[0] = '{1'b0, 4'b0000, 4'b1010, 4'b1010, 4'b0000, 4'b1010};
        vecs[1] = '{1'b0, 4'b1010, 4'b0110, 4'b0100, 4'b1000, 4'b0110};
        vecs[2] = '{1'b1, 4'b1010, 4'b0110, 4'b1100, 4'b1100, 4'b0110};
        vecs[3] = '{1'b0, 4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b0110};
        vecs[4] = '{1'b1, 4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b0110};
        vecs[5] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
        vecs[6] = '{1'b1, 4'b0101, 4'b1010, 4'b1111, 4'b1111, 4'b1010};
        vecs[7] = '{1'b0, 4'b0011, 4'b0101, 4'b0100, 4'b0010, 4'b0101};

        b2b_tgt = '{4'b1010, 4'b0110, 4'b0110, 4'b1001};
        b2b_j   = '{4'b1010, 4'b0100, 4'b0000, 4'b1001};
        b2b_k   = '{4'b0000, 4'b1000, 4'b0000, 4'b0110};

        // Reset state, both instances.
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_ready", ready_s, 0);
            chk("rst_busy", busy_s, 0);
            chk("rst_j", j_s, 0);
            chk("rst_k", k_s, 0);
            chk("rst_done", done_s, 0);
            chk("rst_err", err_s, 0);
            chk("rst_mask", mask_s, 0);
            chk("rst_count", cnt_s, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        sel = 1'b0;
        #1;
        chk("ready_after_rst", ready_s, 1);

        // Table-driven single transfers across both styles.
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].sel, vecs[i].q0, vecs[i].tgt, vecs[i].ej, vecs[i].ek,
                    vecs[i].eq, 1'b0, 4'b0000, 8'd0);
        end

        // Stuck-at-0 on bit 0: every transfer errors, count saturates at 255.
        stuck = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            run_txn(1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001,
                    (i < 255) ? 8'(i + 1) : 8'd255);
        end
        stuck = 4'b0000;
        sel = 1'b1;
        #1;
        chk("style1_count_untouched", cnt_s, 0);

        // Back-to-back with tgt_valid held: done coincides with the next accept.
        sel = 1'b0;
        load_bank(4'b0000);
        tgt_valid = 1'b1;
        tgt_data = b2b_tgt[0];
        for (int i = 0; i < 4; i++) begin
            chk("b2b_ready", ready_s, 1);
            @(negedge clk);
            chk("b2b_drive_ready", ready_s, 0);
            chk("b2b_drive_busy", busy_s, 1);
            chk("b2b_j", j_s, b2b_j[i]);
            chk("b2b_k", k_s, b2b_k[i]);
            @(negedge clk);
            chk("b2b_check_ready", ready_s, 0);
            chk("b2b_check_done", done_s, 0);
            @(negedge clk);
            chk("b2b_done", done_s, 1);
            chk("b2b_err", err_s, 0);
            chk("b2b_q", q_s, b2b_tgt[i]);
            if (i < 3) tgt_data = b2b_tgt[i + 1];
            else tgt_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_idle_busy", busy_s, 0);
        chk("b2b_count", cnt_s, 255);

        // Reset during DRIVE aborts the transfer and clears the count.
        load_bank(4'b0000);
        tgt_valid = 1'b1;
        tgt_data = 4'b1111;
        @(negedge clk);
        tgt_valid = 1'b0;
        chk("abort_drive_j", j_s, 4'b1111);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_j", j_s, 0);
        chk("abort_k", k_s, 0);
        chk("abort_done", done_s, 0);
        chk("abort_count", cnt_s, 0);
        chk("abort_ready_in_rst", ready_s, 0);
        chk("abort_busy", busy_s, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", ready_s, 1);
        chk("abort_no_done", done_s, 0);
        @(negedge clk);
        chk("abort_no_done2", done_s, 0);
        chk("abort_no_err", err_s, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
